mem_stage_lsu: RTL
==================

# mem_stage_lsu

Parametrised memory-access pipeline stage between EX and WB. Registers the EX result and control, waits for the data-SRAM load response when needed, aligns and sign/zero-extends the loaded data, and presents the writeback result to WB. Uses a valid/ready handshake instead of a global stall bus. Exposes an ID-forwarding port that includes a load-pending flag for load-use interlock. Drops stale responses from loads that were flushed.

## Interface
- DATA_W, 32: register and SRAM data width, 32 or 64.
- PC_W, 32: PC width.
- RF_AW, 5: register-file address width.
- DROP_W, 2: width of the stale-response drop counter.
- OFF_W is derived, not overridable: clog2(DATA_W/8).
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous active-low reset.
- flush  in  1  kill the held entry; takes priority over any accept.
- in_valid  in  1  EX presents an entry.
- in_ready  out  1  stage accepts this cycle.
- in_pc  in  PC_W  instruction PC.
- in_rf_we  in  1  writes the register file.
- in_rf_waddr  in  RF_AW  destination register.
- in_ex_result  in  DATA_W  ALU/address result.
- in_is_load  in  1  result comes from memory.
- in_ld_size  in  2  load size: 0 = byte, 1 = half, 2 = word, 3 = dword.
- in_ld_unsigned  in  1  zero-extend when 1, sign-extend when 0.
- in_addr_lo  in  OFF_W  byte offset within the SRAM word.
- data_sram_rvalid  in  1  load response valid.
- data_sram_rdata  in  DATA_W  load response data.
- out_valid  out  1  WB entry valid.
- out_ready  in  1  WB accepts.
- out_pc  out  PC_W  PC of the entry.
- out_rf_we  out  1  write enable of the entry.
- out_rf_waddr  out  RF_AW  destination register of the entry.
- out_rf_wdata  out  DATA_W  writeback data.
- fwd_we  out  1  fwd_wdata is usable for forwarding.
- fwd_waddr  out  RF_AW  destination register being forwarded.
- fwd_wdata  out  DATA_W  forwarded data.
- fwd_pending  out  1  a load to fwd_waddr is outstanding; ID must stall on a match.

## Operation
- States:
  - EMPTY: nothing held.
  - WAIT_LD: load accepted, response not yet received.
  - HOLD: result held for WB.
- in_ready = !flush && drop_cnt != max && (EMPTY || (HOLD && out_ready)).
- Accepting an entry:
  - with in_is_load = 1: go to WAIT_LD.
  - otherwise: latch in_ex_result as the result and go to HOLD.
- WAIT_LD with rvalid and drop_cnt == 0: latch the aligned result and go to HOLD.
- HOLD with out_ready and no accept: go to EMPTY.
- Alignment:
  - Shift data_sram_rdata right by addr_lo*8, having first cleared the low log2(size) bits of addr_lo.
  - Take the low 8/16/32/64 bits, then extend to DATA_W by in_ld_unsigned.
  - Size 3 with DATA_W = 32 is treated as size 2.
- Flush:
  - Any state goes to EMPTY.
  - If flush occurs in WAIT_LD, or together with acceptance of a load, drop_cnt increments.
- Drop counter:
  - Any rvalid while drop_cnt > 0 decrements drop_cnt and is discarded.
  - rvalid in EMPTY or HOLD with drop_cnt == 0 is ignored.
- Outputs:
  - out_valid = HOLD.
  - out_* come from the held registers.
  - fwd_we = HOLD && rf_we; fwd_pending = WAIT_LD && rf_we; fwd_waddr = held waddr.
  - fwd_wdata = held result.
- Reset value of every output: out_valid, out_pc, out_rf_we, out_rf_waddr, out_rf_wdata, fwd_we, fwd_waddr, fwd_wdata and fwd_pending are 0; in_ready is 1. Internal state resets to EMPTY with drop_cnt = 0.

## Timing
- Non-load: accept at edge N gives out_valid in cycle N+1, the same latency as a simple pipeline register.
- Load: response sampled at edge K gives out_valid in cycle K+1. The response can arrive no earlier than the cycle after acceptance.
- Throughput: one entry per cycle for back-to-back non-loads when out_ready is held at 1.
- All outputs are driven from registers. in_ready depends combinationally on out_ready and flush only.
- Reset asserted mid-load clears all state immediately. Any later response falls outside the protocol; the SRAM is reset together with this stage.

## Structure
- Shared package mem_stage_pkg holds:
  - ld_size enum (LD_B, LD_H, LD_W, LD_D);
  - state enum (EMPTY, WAIT_LD, HOLD);
  - packed struct for the EX-to-MEM fields and for the forwarding bundle.
- Sub-module load_align is combinational: rdata, addr_lo, size and unsigned in; extended data out. It is reused by a future cache refill path.

## Test plan
- Non-load: ex_result 0x1234_5678, rf_we = 1, waddr = 3 -> out_valid the next cycle with wdata 0x1234_5678; fwd_we = 1, fwd_waddr = 3.
- Load byte, signed, addr_lo = 2, rdata 0x0080_0000, response 2 cycles after accept:
  - fwd_pending = 1 for 2 cycles;
  - then wdata = 0xFFFF_FF80.
  - Repeat with unsigned -> 0x0000_0080.
- Half, addr_lo = 2, rdata 0x8001_0000, signed -> 0xFFFF_8001. Word -> unchanged.
- out_ready = 0 for 3 cycles while in HOLD -> in_ready = 0 and outputs stable. When out_ready rises, the next entry is accepted in the same cycle.
- Flush in WAIT_LD, then a new load accepted before the stale rvalid:
  - first rvalid is discarded, with drop_cnt going 1 -> 0;
  - second rvalid produces the result;
  - at drop_cnt = 3, in_ready = 0.
- Assert rst in WAIT_LD -> out_valid, fwd_pending and all other outputs are 0 immediately, and in_ready = 1 while reset is held.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types for the MEM-stage load/store unit and its load aligner.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2,
    LD_D = 2'd3
  } ld_size_e;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    WAIT_LD = 2'd1,
    HOLD    = 2'd2
  } state_e;

  // Width-independent control carried from EX; parametric fields live beside it.
  typedef struct packed {
    logic     rfWe;
    ld_size_e ldSize;
    logic     ldUnsigned;
  } ex_ctrl_t;

  typedef struct packed {
    logic we;
    logic pending;
  } fwd_flags_t;

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Combinational load aligner: picks the addressed byte/half/word/dword and extends it.
module load_align
  import mem_stage_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [OFF_W-1:0]  addr_lo_i,
  input  ld_size_e          size_i,
  input  logic              ldUnsigned_i,
  output logic [DATA_W-1:0] data_o
);

  ld_size_e          effSize;
  logic [OFF_W-1:0]  off;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] shifted;
  logic              signBit;

  // A dword request on a 32-bit datapath degrades to a word access.
  always_comb begin
    effSize = size_i;
    if (DATA_W == 32 && size_i == LD_D) effSize = LD_W;
    off  = addr_lo_i;
    mask = '1;
    unique case (effSize)
      LD_B: mask = DATA_W'(8'hFF);
      LD_H: begin
        off  = addr_lo_i & ~OFF_W'(1);
        mask = DATA_W'(16'hFFFF);
      end
      LD_W: begin
        off  = addr_lo_i & ~OFF_W'(3);
        mask = DATA_W'(32'hFFFF_FFFF);
      end
      default: begin
        off  = '0;
        mask = '1;
      end
    endcase
  end

  assign shifted = rdata_i >> {off, 3'b000};

  always_comb begin
    signBit = shifted[DATA_W-1];
    unique case (effSize)
      LD_B:    signBit = shifted[7];
      LD_H:    signBit = shifted[15];
      LD_W:    signBit = shifted[31];
      default: signBit = shifted[DATA_W-1];
    endcase
  end

  assign data_o = (shifted & mask) | ({DATA_W{signBit & ~ldUnsigned_i}} & ~mask);

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: holds one EX entry, waits for its load response, aligns it and
// hands the result to WB over valid/ready, discarding responses of flushed loads.
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int PC_W   = 32,
  parameter  int RF_AW  = 5,
  parameter  int DROP_W = 2,
  localparam int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_rf_we,
  input  logic [RF_AW-1:0]  in_rf_waddr,
  input  logic [DATA_W-1:0] in_ex_result,
  input  logic              in_is_load,
  input  logic [1:0]        in_ld_size,
  input  logic              in_ld_unsigned,
  input  logic [OFF_W-1:0]  in_addr_lo,
  input  logic              data_sram_rvalid,
  input  logic [DATA_W-1:0] data_sram_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_rf_we,
  output logic [RF_AW-1:0]  out_rf_waddr,
  output logic [DATA_W-1:0] out_rf_wdata,
  output logic              fwd_we,
  output logic [RF_AW-1:0]  fwd_waddr,
  output logic [DATA_W-1:0] fwd_wdata,
  output logic              fwd_pending
);

  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  state_e              state_q, state_d;
  ex_ctrl_t            ctrl_q, ctrl_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [RF_AW-1:0]    rfWaddr_q, rfWaddr_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [OFF_W-1:0]    addrLo_q, addrLo_d;
  logic [DROP_W-1:0]   dropCnt_q, dropCnt_d;

  logic                canTake;
  logic                accept;
  logic                dropInc;
  logic                dropDec;
  logic [DATA_W-1:0]   alignedData;
  fwd_flags_t          fwdFlags;

  load_align #(.DATA_W(DATA_W)) u_align (
    .rdata_i      (data_sram_rdata),
    .addr_lo_i    (addrLo_q),
    .size_i       (ctrl_q.ldSize),
    .ldUnsigned_i (ctrl_q.ldUnsigned),
    .data_o       (alignedData)
  );

  assign canTake  = (dropCnt_q != DROP_MAX) &&
                    ((state_q == EMPTY) || ((state_q == HOLD) && out_ready));
  assign in_ready = !flush && canTake;
  assign accept   = in_valid && in_ready;

  // A flushed load owes one stale response, unless its own response lands in the flush cycle.
  assign dropDec = data_sram_rvalid && (dropCnt_q != '0);
  assign dropInc = flush &&
                   (((state_q == WAIT_LD) && !(data_sram_rvalid && (dropCnt_q == '0))) ||
                    (in_valid && in_is_load && canTake));

  always_comb begin
    dropCnt_d = dropCnt_q;
    unique case ({dropInc, dropDec})
      2'b10:   dropCnt_d = dropCnt_q + DROP_W'(1);
      2'b01:   dropCnt_d = dropCnt_q - DROP_W'(1);
      default: dropCnt_d = dropCnt_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    pc_d      = pc_q;
    rfWaddr_d = rfWaddr_q;
    result_d  = result_q;
    addrLo_d  = addrLo_q;
    unique case (state_q)
      WAIT_LD: begin
        if (data_sram_rvalid && (dropCnt_q == '0)) begin
          state_d  = HOLD;
          result_d = alignedData;
        end
      end
      HOLD:    if (out_ready) state_d = EMPTY;
      default: state_d = state_q;
    endcase
    if (accept) begin
      ctrl_d    = '{rfWe: in_rf_we, ldSize: ld_size_e'(in_ld_size), ldUnsigned: in_ld_unsigned};
      pc_d      = in_pc;
      rfWaddr_d = in_rf_waddr;
      addrLo_d  = in_addr_lo;
      if (in_is_load) begin
        state_d = WAIT_LD;
      end else begin
        state_d  = HOLD;
        result_d = in_ex_result;
      end
    end
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= EMPTY;
      ctrl_q    <= '0;
      pc_q      <= '0;
      rfWaddr_q <= '0;
      result_q  <= '0;
      addrLo_q  <= '0;
      dropCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      pc_q      <= pc_d;
      rfWaddr_q <= rfWaddr_d;
      result_q  <= result_d;
      addrLo_q  <= addrLo_d;
      dropCnt_q <= dropCnt_d;
    end
  end

  assign fwdFlags = '{we:      (state_q == HOLD) && ctrl_q.rfWe,
                      pending: (state_q == WAIT_LD) && ctrl_q.rfWe};

  assign out_valid    = (state_q == HOLD);
  assign out_pc       = pc_q;
  assign out_rf_we    = ctrl_q.rfWe;
  assign out_rf_waddr = rfWaddr_q;
  assign out_rf_wdata = result_q;
  assign fwd_we       = fwdFlags.we;
  assign fwd_pending  = fwdFlags.pending;
  assign fwd_waddr    = rfWaddr_q;
  assign fwd_wdata    = result_q;

endmodule
